// File: rtl/bnn_act_packer.sv
// bnn_act_packer
//   Collects 1-bit neuron decisions (one per in_valid/in_ready handshake),
//   packs them LSB-first into N-bit activation words and writes each completed
//   word into the next layer's activation store through a single-port write
//   port (we/addr/dx, accepted on we & wr_ready).
//
// Parameters
//   N        activation word width in bits
//   DEPTH    words per frame (need not be a power of two)
//   PAD_BIT  fill value for unfilled bit positions of a flushed word
//
// Ports
//   clk         clock, rising edge
//   rstn        synchronous active-low reset
//   in_valid    in_bit is valid this cycle
//   in_bit      neuron decision bit
//   in_ready    packer accepts in_bit this cycle (combinational from wr_ready)
//   flush       close the current partial word and frame (level)
//   we          write request, held until accepted
//   wr_ready    store accepts the write this cycle
//   addr        word address of the pending write
//   dx          packed word
//   frame_done  high with the pending write that ends a frame
//
// Build option
//   BNN_PACK_FLUSH_EN  when defined, flush closes partial words/frames;
//                      otherwise flush is ignored and frames end on the
//                      word counter wrap.
module bnn_act_packer #(
    parameter int unsigned N       = 256,
    parameter int unsigned DEPTH   = 8,
    parameter logic        PAD_BIT = 1'b0
) (
    input  logic                                     clk,
    input  logic                                     rstn,
    input  logic                                     in_valid,
    input  logic                                     in_bit,
    output logic                                     in_ready,
    input  logic                                     flush,
    output logic                                     we,
    input  logic                                     wr_ready,
    output logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] addr,
    output logic [N-1:0]                             dx,
    output logic                                     frame_done
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned BW = (N > 1) ? $clog2(N) : 1;
    localparam logic [BW-1:0] LAST_BIT  = BW'(N - 1);
    localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH - 1);

    logic [N-1:0]  pack;
    logic [BW-1:0] bit_cnt;
    logic [AW-1:0] word_cnt;

    logic          accept;
    logic          word_done;
    logic          wr_accept;
    logic [N-1:0]  pack_placed;

    logic          load;
    logic [N-1:0]  load_data;
    logic          load_fd;
    logic [N-1:0]  pack_d;
    logic [BW-1:0] bit_cnt_d;
    logic [AW-1:0] word_cnt_d;

    // Stall input only when a full word would have nowhere to go.
    assign in_ready  = rstn & ~(we & ~wr_ready & (bit_cnt == LAST_BIT));
    assign accept    = in_valid & in_ready;
    assign word_done = accept & (bit_cnt == LAST_BIT);
    assign wr_accept = we & wr_ready;

`ifdef BNN_PACK_FLUSH_EN
    logic          flush_take;
    int unsigned   filled;
    logic [N-1:0]  padded;

    // A flushed partial word also needs the output register, so flush is
    // only taken when no stalled write occupies it.
    assign flush_take = flush & in_ready & ~(we & ~wr_ready);
`else
    logic flush_unused;
    assign flush_unused = flush;
`endif

    always_comb begin
        pack_placed = pack;
        if (accept) begin
            pack_placed[bit_cnt] = in_bit;
        end

        load       = word_done;
        load_data  = pack_placed;
        load_fd    = (word_cnt == LAST_WORD);
        pack_d     = word_done ? '0 : pack_placed;
        bit_cnt_d  = bit_cnt;
        word_cnt_d = word_cnt;

        if (word_done) begin
            bit_cnt_d  = '0;
            word_cnt_d = (word_cnt == LAST_WORD) ? '0 : word_cnt + AW'(1);
        end else if (accept) begin
            bit_cnt_d  = bit_cnt + BW'(1);
        end

`ifdef BNN_PACK_FLUSH_EN
        filled = int'(bit_cnt) + (accept ? 1 : 0);
        padded = '0;
        for (int unsigned i = 0; i < N; i++) begin
            padded[i] = (i < filled) ? pack_placed[i] : PAD_BIT;
        end

        if (flush_take) begin
            word_cnt_d = '0;
            if (word_done) begin
                load_fd = 1'b1;
            end else if (filled != 0) begin
                load      = 1'b1;
                load_fd   = 1'b1;
                load_data = padded;
                pack_d    = '0;
                bit_cnt_d = '0;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pack       <= '0;
            bit_cnt    <= '0;
            word_cnt   <= '0;
            we         <= 1'b0;
            addr       <= '0;
            dx         <= '0;
            frame_done <= 1'b0;
        end else begin
            pack     <= pack_d;
            bit_cnt  <= bit_cnt_d;
            word_cnt <= word_cnt_d;
            // A load can coincide with a write accept; the new word wins and
            // we stays high. Loads never occur while a write is stalled.
            if (load) begin
                we         <= 1'b1;
                addr       <= word_cnt;
                dx         <= load_data;
                frame_done <= load_fd;
            end else if (wr_accept) begin
                we         <= 1'b0;
                frame_done <= 1'b0;
            end
        end
    end

endmodule
